// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges NUM_REQ byte streams into one UART TX stream,
// switching owners only on message boundaries (or on an idle timeout).
module uart_tx_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          TAG_EN   = 1,
  parameter logic [7:0]  TAG_BASE = 8'h30,
  parameter int          TIMEOUT  = 1024,
  localparam int         IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 busy_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // IDLE: pick next owner | TAG: emit owner tag byte | PASS: forward owner bytes
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_PASS} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_owner_q, last_owner_d;
  logic [CW-1:0]  idle_cnt_q, idle_cnt_d;

  logic [7:0]     req_byte [NUM_REQ];
  logic           sel_valid;
  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] cand;
  logic           own_valid;
  logic           own_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data_i[8*i +: 8];
  end

  // Search starts just past the previous owner, so the last owner has lowest priority.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_owner_q) + k) % NUM_REQ);
      if (!sel_valid && req_valid_i[cand]) begin
        sel_valid = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign own_valid = req_valid_i[grant_q];
  assign own_last  = req_last_i[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    idle_cnt_d   = idle_cnt_q;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    req_ready_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_d    = sel_id;
          idle_cnt_d = '0;
          state_d    = (TAG_EN != 0) ? S_TAG : S_PASS;
        end
      end
      S_TAG: begin
        tx_valid_o = 1'b1;
        tx_data_o  = TAG_BASE + 8'(grant_q);
        if (tx_ready_i) state_d = S_PASS;
      end
      S_PASS: begin
        tx_valid_o           = own_valid;
        tx_data_o            = req_byte[grant_q];
        req_ready_o[grant_q] = tx_ready_i;
        if (own_valid && tx_ready_i) begin
          if (own_last) begin
            last_owner_d = grant_q;
            state_d      = S_IDLE;
          end else begin
            idle_cnt_d = '0;
          end
        end else if (!own_valid && TIMEOUT != 0) begin
          // Revoke only while the owner is silent, so a presented byte is never cut.
          if (int'(idle_cnt_q) == TIMEOUT - 1) begin
            last_owner_d = grant_q;
            state_d      = S_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_owner_q <= IDW'(NUM_REQ - 1);
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter; expected TX stream comes from a
// message-level round-robin model over the queued messages.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic          tx_valid, tx_ready;
  logic [7:0]    tx_data;
  logic [1:0]    grant_id;
  logic          busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .TAG_EN(1), .TAG_BASE(8'h30), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .grant_id_o(grant_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]    dq [NR][$];
  bit            lq [NR][$];
  logic [7:0]    exp_d [$];
  logic [NR-1:0] exp_r [$];
  int            n_chk = 0, n_pass = 0;
  int            m_last;
  bit            bp;
  bit            stall_pend;
  logic [7:0]    stall_data;
  int            busy_cnt;
  logic          s_busy, s_txv;
  int            idle_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_msg(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      dq[r].push_back(s[i]);
      lq[r].push_back(i == s.len() - 1);
    end
  endtask

  // Message-level round robin: next requester with a queued message after m_last
  // sends tag then its whole message.
  task automatic model_build();
    int ptr [NR];
    int c;
    bit found;
    bit l;
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) ptr[i] = 0;
    c = 0;
    while (1) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (ptr[c] < dq[c].size()) begin
          found = 1;
          break;
        end
      end
      if (!found) break;
      exp_d.push_back(8'h30 + 8'(c));
      exp_r.push_back('0);
      m = '0;
      m[c] = 1'b1;
      do begin
        exp_d.push_back(dq[c][ptr[c]]);
        exp_r.push_back(m);
        l = lq[c][ptr[c]];
        ptr[c]++;
      end while (!l && ptr[c] < dq[c].size());
      m_last = c;
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < NR; i++) begin
      if (dq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = dq[i][0];
        req_last[i] = lq[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    s_busy = busy;
    s_txv  = tx_valid;
    if (busy) busy_cnt++;
    if (stall_pend) begin
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, stall_data);
    end
    if (tx_valid && tx_ready) begin
      check("tx_expected", exp_d.size() > 0, 1);
      if (exp_d.size() > 0) begin
        check("tx_data", tx_data, exp_d.pop_front());
        check("req_ready", req_ready, exp_r.pop_front());
      end
    end
    stall_pend = tx_valid && !tx_ready;
    stall_data = tx_data;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) begin
        void'(dq[i].pop_front());
        void'(lq[i].pop_front());
      end
    @(negedge clk);
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (exp_d.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("run_done", exp_d.size(), 0);
  endtask

  initial begin
    int nm, len;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    bp = 0; stall_pend = 0; busy_cnt = 0; m_last = NR - 1;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b0;
    @(negedge clk);

    // contention: r1 and r3 together after reset, r1 first
    push_msg(1, "ab");
    push_msg(3, "xyz");
    model_build();
    run(100);

    // single requester "hi\n" with one-cycle bubble and 4 busy cycles
    push_msg(0, "hi\n");
    model_build();
    busy_cnt = 0;
    cycle();
    check("t1_bubble_busy", s_busy, 0);
    check("t1_bubble_txv", s_txv, 0);
    run(50);
    cycle();
    check("t1_busy_cycles", busy_cnt, 4);
    check("t1_back_idle", s_busy, 0);

    // fairness: everyone holds single-byte messages
    for (int i = 0; i < NR; i++) begin
      push_msg(i, "p");
      push_msg(i, "q");
      push_msg(i, "r");
    end
    model_build();
    run(200);

    // random messages with random backpressure
    bp = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) begin
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            dq[i].push_back(8'($urandom_range(32, 126)));
            lq[i].push_back(b == len - 1);
          end
        end
      end
      model_build();
      run(600);
    end
    bp = 0;
    stall_pend = 0;

    // timeout: r2 sends one unterminated byte then goes silent
    dq[2].push_back(8'h41);
    lq[2].push_back(1'b0);
    exp_d.push_back(8'h32); exp_r.push_back(4'b0000);
    exp_d.push_back(8'h41); exp_r.push_back(4'b0100);
    run(50);
    push_msg(0, "Z");
    idle_n = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (!s_busy) break;
      if (!s_txv) idle_n++;
    end
    check("t5_idle_cycles", idle_n, TO);
    exp_d.push_back(8'h30); exp_r.push_back(4'b0000);
    exp_d.push_back(8'h5a); exp_r.push_back(4'b0001);
    run(50);
    m_last = 0;
    push_msg(2, "B");
    model_build();
    run(50);

    // async reset in the middle of a message
    push_msg(1, "012345");
    model_build();
    repeat (4) cycle();
    #2;
    check("t6_pre_valid", tx_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_rst_busy", busy, 0);
    for (int i = 0; i < NR; i++) begin
      dq[i].delete();
      lq[i].delete();
    end
    exp_d.delete();
    exp_r.delete();
    stall_pend = 0;
    m_last = NR - 1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) push_msg(i, "k");
    model_build();
    run(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
